// File: rtl/byte_assembler32_pkg.sv
// byte_assembler32_pkg
//   Shared types and constants for the byte_assembler32 slice.
//   state_e  : assembler FSM state (S_FILL collects bytes, S_HOLD presents a word)
//   WORD_W   : assembled word width
//   BYTE_W   : input byte width
//   NUM_BYTES: bytes per word
//   CNT_W    : width of the byte-lane counter
package byte_assembler32_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = 4;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/byte_lane_dec.sv
// byte_lane_dec
//   Decodes the 2-bit lane counter into one-hot accumulator lane write enables,
//   gated by the byte-accept strobe.
//   cnt     : in  current lane index
//   en      : in  byte accepted this cycle
//   lane_en : out one-hot lane write enable (all zero when en=0)
module byte_lane_dec
    import byte_assembler32_pkg::*;
(
    input  logic [CNT_W-1:0]     cnt,
    input  logic                 en,
    output logic [NUM_BYTES-1:0] lane_en
);

    always_comb begin
        lane_en = '0;
        if (en) begin
            unique case (cnt)
                2'd0: lane_en = 4'b0001;
                2'd1: lane_en = 4'b0010;
                2'd2: lane_en = 4'b0100;
                2'd3: lane_en = 4'b1000;
                default: lane_en = '0;
            endcase
        end
    end

endmodule

// File: rtl/byte_assembler32.sv
// byte_assembler32
//   Packs a valid/ready byte stream little-endian into 32-bit words for the
//   data register. A word is emitted after 4 bytes, or early on in_last with the
//   unused upper lanes zero. One bubble cycle per word (no bypass in S_HOLD).
//   Optional macro BYTE_ASSEMBLER32_PARITY_EN adds out_parity = ^out_word.
//   Ports:
//     clk        in   rising-edge clock
//     reset_n    in   synchronous active-low reset
//     in_byte    in   input byte
//     in_valid   in   in_byte valid
//     in_last    in   byte ends the word early (qualified by in_valid)
//     in_ready   out  block can accept a byte
//     out_word   out  assembled word
//     out_bytes  out  number of valid bytes in out_word (1..4)
//     out_valid  out  out_word valid
//     out_parity out  XOR-reduce of out_word (only with BYTE_ASSEMBLER32_PARITY_EN)
//     out_ready  in   downstream accepts the word
module byte_assembler32 #(
    parameter int unsigned NUM_BYTES = 4,
    parameter int unsigned BYTE_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [BYTE_W-1:0]             in_byte,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_BYTES*BYTE_W-1:0]   out_word,
    output logic [2:0]                    out_bytes,
    output logic                          out_valid,
`ifdef BYTE_ASSEMBLER32_PARITY_EN
    output logic                          out_parity,
`endif
    input  logic                          out_ready
);

    import byte_assembler32_pkg::*;

    if (NUM_BYTES != 4 || BYTE_W != 8) begin : g_bad_cfg
        $error("byte_assembler32 supports only NUM_BYTES=4, BYTE_W=8");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WORD_W-1:0]  acc_q;
    logic [WORD_W-1:0]  acc_merged;
    logic [WORD_W-1:0]  out_word_q;
    logic [2:0]         out_bytes_q;
    logic               out_valid_q;
    logic [3:0]         lane_en;
    logic               accept;

    assign in_ready = (state_q == S_FILL);
    assign accept   = in_valid & in_ready;

    byte_lane_dec u_lane_dec (
        .cnt     (cnt_q),
        .en      (accept),
        .lane_en (lane_en)
    );

    // Lanes above cnt are always zero here (accumulator is cleared on every
    // return to S_FILL), so the merged value is already zero-padded.
    always_comb begin
        acc_merged = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                acc_merged[i*8 +: 8] = in_byte;
            end
        end
    end

`ifdef BYTE_ASSEMBLER32_PARITY_EN
    logic out_parity_q;
    assign out_parity = out_parity_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_word_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
`ifdef BYTE_ASSEMBLER32_PARITY_EN
            out_parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_FILL: begin
                    if (accept) begin
                        acc_q <= acc_merged;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == 2'd3 || in_last) begin
                            state_q     <= S_HOLD;
                            out_word_q  <= acc_merged;
                            out_bytes_q <= {1'b0, cnt_q} + 3'd1;
                            out_valid_q <= 1'b1;
`ifdef BYTE_ASSEMBLER32_PARITY_EN
                            out_parity_q <= ^acc_merged;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    // out_word/out_bytes deliberately keep their values after the handshake.
                    if (out_ready) begin
                        state_q     <= S_FILL;
                        cnt_q       <= '0;
                        acc_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign out_word  = out_word_q;
    assign out_bytes = out_bytes_q;
    assign out_valid = out_valid_q;

endmodule
